// File: rtl/lane_reuse_scheduler.sv
// lane_reuse_scheduler: shares one registered data lane between two requesters
// feeding a lane-reuse demux (requester 0 -> outlane1, requester 1 -> outlane2).
// Round-robin arbitration, bursts of at most MaxBurst beats, and one idle
// turnaround cycle between grants. The demux select is delayed one cycle behind
// datalane so that it lines up with the demux input register.
// Optional build macro LANE_SCHED_STATS_EN adds saturating beat/turn counters.
module lane_reuse_scheduler #(
  parameter int Width    = 8,
  parameter int MaxBurst = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic [Width-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [Width-1:0] req1_data,
  output logic             req1_ready,
  output logic [Width-1:0] datalane,
  output logic             sel0x,
  output logic             sel1x,
  output logic             busy
`ifdef LANE_SCHED_STATS_EN
  ,
  output logic [15:0]      beats0,
  output logic [15:0]      beats1,
  output logic [15:0]      turn_count
`endif
);

  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(MaxBurst - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [Width-1:0]  datalane_q, datalane_d;
  logic [1:0]        sel_pend_q, sel_pend_d;
  logic [1:0]        sel_q, sel_d;
  logic              beat0, beat1;

  // Ready depends only on the registered grant state, so it can never be high for both.
  assign req0_ready = (state_q == GRANT0);
  assign req1_ready = (state_q == GRANT1);
  assign beat0      = req0_valid && req0_ready;
  assign beat1      = req1_valid && req1_ready;

  assign datalane = datalane_q;
  assign sel0x    = sel_q[0];
  assign sel1x    = sel_q[1];
  assign busy     = (state_q != IDLE);

  // Next-state: arbitration in IDLE/TURN, burst accounting while granted.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE, TURN: begin
        burst_cnt_d = '0;
        // On a tie the requester that was not granted last time wins.
        if (req0_valid && (!req1_valid || last_grant_q)) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
        end else if (req1_valid) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (beat0 || beat1) begin
          if (burst_cnt_q == LastBeat) begin
            state_d     = TURN;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else begin
          // Requester withdrew: the rest of its burst allowance is forfeited.
          state_d     = TURN;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Datapath: the lane carries the beat one cycle after acceptance, select one cycle later still.
  always_comb begin
    datalane_d = '0;
    if (beat0) begin
      datalane_d = req0_data;
    end else if (beat1) begin
      datalane_d = req1_data;
    end
    sel_pend_d = {beat1, beat0};
    sel_d      = sel_pend_q;
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
      datalane_q   <= '0;
      sel_pend_q   <= 2'b00;
      sel_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      datalane_q   <= datalane_d;
      sel_pend_q   <= sel_pend_d;
      sel_q        <= sel_d;
    end
  end

`ifdef LANE_SCHED_STATS_EN
  logic [15:0] beats0_q, beats0_d;
  logic [15:0] beats1_q, beats1_d;
  logic [15:0] turn_count_q, turn_count_d;

  assign beats0     = beats0_q;
  assign beats1     = beats1_q;
  assign turn_count = turn_count_q;

  // Saturating statistics counters.
  always_comb begin
    beats0_d     = beats0_q;
    beats1_d     = beats1_q;
    turn_count_d = turn_count_q;
    if (beat0 && (beats0_q != 16'hFFFF)) begin
      beats0_d = beats0_q + 16'd1;
    end
    if (beat1 && (beats1_q != 16'hFFFF)) begin
      beats1_d = beats1_q + 16'd1;
    end
    if ((state_q == TURN) && (turn_count_q != 16'hFFFF)) begin
      turn_count_d = turn_count_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beats0_q     <= '0;
      beats1_q     <= '0;
      turn_count_q <= '0;
    end else begin
      beats0_q     <= beats0_d;
      beats1_q     <= beats1_d;
      turn_count_q <= turn_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_lane_reuse_scheduler.sv
// Testbench for lane_reuse_scheduler: scoreboard of accepted beats checked
// against the demux-facing lane/select outputs, plus directed grant-pattern,
// reset and (when LANE_SCHED_STATS_EN is defined) statistics checks.
module tb_lane_reuse_scheduler;

  localparam int Width = 8;

  typedef struct packed {
    logic [1:0]       sel;
    logic [Width-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic             req0_valid, req1_valid;
  logic [Width-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic [Width-1:0] datalane;
  logic             sel0x, sel1x, busy;
`ifdef LANE_SCHED_STATS_EN
  logic [15:0]      beats0, beats1, turn_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [Width-1:0] src0[$];
  logic [Width-1:0] src1[$];
  beat_t            exp_q[$];
  logic             en0, en1;
  logic [Width-1:0] prev_lane;

  lane_reuse_scheduler #(.Width(Width), .MaxBurst(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .datalane   (datalane),
    .sel0x      (sel0x),
    .sel1x      (sel1x),
    .busy       (busy)
`ifdef LANE_SCHED_STATS_EN
    ,
    .beats0     (beats0),
    .beats1     (beats1),
    .turn_count (turn_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present the head of each source queue to the DUT.
  task automatic drive();
    req0_valid = en0 && (src0.size() != 0);
    req0_data  = (src0.size() != 0) ? src0[0] : '0;
    req1_valid = en1 && (src1.size() != 0);
    req1_data  = (src1.size() != 0) ? src1[0] : '0;
  endtask

  // One clock cycle: record the handshake about to be taken, then check outputs at negedge.
  task automatic step();
    logic  f0, f1;
    logic [1:0] s;
    beat_t e;
    f0 = req0_valid && req0_ready;
    f1 = req1_valid && req1_ready;
    if (f0) begin
      e.sel = 2'b01; e.data = req0_data;
      exp_q.push_back(e);
      void'(src0.pop_front());
    end
    if (f1) begin
      e.sel = 2'b10; e.data = req1_data;
      exp_q.push_back(e);
      void'(src1.pop_front());
    end
    @(negedge clk);
    s = {sel1x, sel0x};
    check_eq("sel_not_11", {31'd0, s == 2'b11}, 32'd0);
    check_eq("ready_excl", {31'd0, req0_ready && req1_ready}, 32'd0);
    if (!(f0 || f1)) check_eq("lane_idle", {24'd0, datalane}, 32'd0);
    if (s != 2'b00) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_sel", {30'd0, s}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sel", {30'd0, s}, {30'd0, e.sel});
        check_eq("lane", {24'd0, prev_lane}, {24'd0, e.data});
        $display("beat out: lane=%02h sel=%b", prev_lane, s);
      end
    end
    prev_lane = datalane;
    drive();
  endtask

  task automatic do_reset();
    en0 = 1'b0; en1 = 1'b0;
    src0.delete(); src1.delete();
    drive();
    @(negedge clk);
    resetn = 1'b0;
    exp_q.delete();
    prev_lane = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int code, exp_code;
    logic [1:0] s;
    en0 = 1'b1; en1 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      src0.push_back(8'h10 + 8'(i));
      src1.push_back(8'h80 + 8'(i));
    end
    prev_lane = '0;
    resetn = 1'b0;
    drive();

    // Reset held with both requesters valid: everything quiet.
    repeat (3) @(negedge clk);
    check_eq("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check_eq("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check_eq("rst_lane", {24'd0, datalane}, 32'd0);
    check_eq("rst_sel", {30'd0, sel1x, sel0x}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;

    // Both continuously valid: 4 x req0, idle, 4 x req1, idle, ... starting with req0.
    for (int k = 0; k < 20; k++) begin
      step();
      code = req0_ready ? 1 : (req1_ready ? 2 : 0);
      exp_code = ((k % 10) < 4) ? 1 : (((k % 10) == 4) || ((k % 10) == 9)) ? 0 : 2;
      check_eq("grant_pattern", code, exp_code);
    end
    en0 = 1'b0; en1 = 1'b0;
    drive();
    repeat (6) step();
    check_eq("sb_empty_t1", exp_q.size(), 0);
    src0.delete(); src1.delete();

    // req0 alone, four beats then TURN and IDLE.
    en0 = 1'b1;
    for (int i = 0; i < 4; i++) src0.push_back(8'hA1 + 8'(i));
    drive();
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("t2_ready0", {31'd0, req0_ready}, (k < 4) ? 32'd1 : 32'd0);
      check_eq("t2_busy", {31'd0, busy}, (k < 5) ? 32'd1 : 32'd0);
    end
    repeat (2) step();
    check_eq("sb_empty_t2", exp_q.size(), 0);
    en0 = 1'b0;

    // req1 sends two beats then drops valid.
    en1 = 1'b1;
    src1.push_back(8'h55);
    src1.push_back(8'h66);
    drive();
    for (int k = 0; k < 5; k++) begin
      step();
      s = {sel1x, sel0x};
      check_eq("t4_ready1", {31'd0, req1_ready}, (k < 3) ? 32'd1 : 32'd0);
      check_eq("t4_sel", {30'd0, s}, (k == 2 || k == 3) ? 32'd2 : 32'd0);
    end
    check_eq("sb_empty_t4", exp_q.size(), 0);
    en1 = 1'b0;

    // Reset while beat 2 of a req0 burst is on offer.
    en0 = 1'b1;
    for (int i = 0; i < 4; i++) src0.push_back(8'hC1 + 8'(i));
    drive();
    step();
    check_eq("t5_ready0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    // C1 was taken at this edge; the requester moves on to C2.
    void'(src0.pop_front());
    check_eq("t5_lane_pre", {24'd0, datalane}, 32'hC1);
    #1;
    resetn = 1'b0;
    #1;
    check_eq("t5_rst_lane", {24'd0, datalane}, 32'd0);
    check_eq("t5_rst_ready0", {31'd0, req0_ready}, 32'd0);
    check_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    prev_lane = '0;
    drive();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_eq("t5_rel_ready0", {31'd0, req0_ready}, 32'd0);
    step();
    check_eq("t5_regrant", {31'd0, req0_ready}, 32'd1);
    check_eq("t5_data_c2", {24'd0, req0_data}, 32'hC2);
    repeat (7) step();
    check_eq("sb_empty_t5", exp_q.size(), 0);

    // Mixed traffic: 6 beats from req0, 3 from req1 after a fresh reset.
    do_reset();
    en0 = 1'b1; en1 = 1'b1;
    for (int i = 0; i < 6; i++) src0.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 3; i++) src1.push_back(8'hE0 + 8'(i));
    drive();
    repeat (20) step();
    check_eq("sb_empty_t6", exp_q.size(), 0);
    check_eq("t6_src0_drained", src0.size(), 0);
    check_eq("t6_src1_drained", src1.size(), 0);
`ifdef LANE_SCHED_STATS_EN
    check_eq("beats0", {16'd0, beats0}, 32'd6);
    check_eq("beats1", {16'd0, beats1}, 32'd3);
    check_eq("turn_count", {16'd0, turn_count}, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
